// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: a registered valid/ready pipeline stage for control and data payloads.
// The outputs come straight from registers, and outCtrl/outData read zero while the stage is empty.
// stallCount saturates and counts the cycles where the stage holds an entry
// that downstream refuses. A flush squashes every held entry.
//
// Build option: define PIPE_STAGE_SKID_EN to add a second (skid) entry.
//   - With the skid entry, inReady comes from a register, so no combinational ready path crosses the stage.
//   - Without it, the stage holds one entry and inReady = !outValid || outReady.

module pipe_stage_reg #(
    parameter int DATA_WIDTH      = 32,
    parameter int CTRL_WIDTH      = 16,
    parameter int STALL_CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       inValid,
    output logic                       inReady,
    input  logic [CTRL_WIDTH-1:0]      inCtrl,
    input  logic [DATA_WIDTH-1:0]      inData,
    output logic                       outValid,
    input  logic                       outReady,
    output logic [CTRL_WIDTH-1:0]      outCtrl,
    output logic [DATA_WIDTH-1:0]      outData,
    output logic [STALL_CNT_WIDTH-1:0] stallCount
);

    localparam logic [STALL_CNT_WIDTH-1:0] STALL_ONE = STALL_CNT_WIDTH'(1'b1);
    localparam logic [STALL_CNT_WIDTH-1:0] STALL_MAX = {STALL_CNT_WIDTH{1'b1}};

    // Saturating increment: once the counter reaches all-ones it stays there.
    function automatic logic [STALL_CNT_WIDTH-1:0] satIncrement(
        input logic [STALL_CNT_WIDTH-1:0] value
    );
        if (value == STALL_MAX) begin
            return value;
        end else begin
            return value + STALL_ONE;
        end
    endfunction

    // Main entry: this is what the stage presents downstream.
    logic                       mainValid_r;
    logic [CTRL_WIDTH-1:0]      mainCtrl_r;
    logic [DATA_WIDTH-1:0]      mainData_r;
    logic                       mainValidNext_s;
    logic [CTRL_WIDTH-1:0]      mainCtrlNext_s;
    logic [DATA_WIDTH-1:0]      mainDataNext_s;

    logic [STALL_CNT_WIDTH-1:0] stallCount_r;
    logic [STALL_CNT_WIDTH-1:0] stallNext_s;

    assign outValid   = mainValid_r;
    assign outCtrl    = mainCtrl_r;
    assign outData    = mainData_r;
    assign stallCount = stallCount_r;

    // Stall counter next value. A flush freezes the count, even on a cycle that is also stalled.
    always_comb begin
        stallNext_s = stallCount_r;
        if (flush) begin
            stallNext_s = stallCount_r;
        end else if (mainValid_r && !outReady) begin
            stallNext_s = satIncrement(stallCount_r);
        end else begin
            stallNext_s = stallCount_r;
        end
    end

    // Stall counter register. Reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            stallCount_r <= '0;
        end else begin
            stallCount_r <= stallNext_s;
        end
    end

`ifdef PIPE_STAGE_SKID_EN

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } stageState_t;

    stageState_t            state_r;
    stageState_t            stateNext_s;
    logic                   inReady_r;
    logic                   inReadyNext_s;
    logic [CTRL_WIDTH-1:0]  skidCtrl_r;
    logic [DATA_WIDTH-1:0]  skidData_r;
    logic [CTRL_WIDTH-1:0]  skidCtrlNext_s;
    logic [DATA_WIDTH-1:0]  skidDataNext_s;
    logic                   accept_s;
    logic                   deliver_s;

    assign inReady   = inReady_r;
    assign accept_s  = inValid && inReady_r;
    assign deliver_s = mainValid_r && outReady;

    // Next-state and next-entry logic. Flush beats both accept and deliver.
    // The skid slot is only filled while main is held, so a single deliver
    // always promotes skid to main.
    always_comb begin
        stateNext_s     = state_r;
        mainValidNext_s = mainValid_r;
        mainCtrlNext_s  = mainCtrl_r;
        mainDataNext_s  = mainData_r;
        skidCtrlNext_s  = skidCtrl_r;
        skidDataNext_s  = skidData_r;
        if (flush) begin
            stateNext_s     = EMPTY;
            mainValidNext_s = 1'b0;
            mainCtrlNext_s  = '0;
            mainDataNext_s  = '0;
            skidCtrlNext_s  = '0;
            skidDataNext_s  = '0;
        end else begin
            case (state_r)
                EMPTY: begin
                    if (accept_s) begin
                        stateNext_s     = ONE;
                        mainValidNext_s = 1'b1;
                        mainCtrlNext_s  = inCtrl;
                        mainDataNext_s  = inData;
                    end else begin
                        stateNext_s = EMPTY;
                    end
                end
                ONE: begin
                    if (accept_s && deliver_s) begin
                        stateNext_s     = ONE;
                        mainCtrlNext_s  = inCtrl;
                        mainDataNext_s  = inData;
                    end else if (accept_s) begin
                        stateNext_s    = TWO;
                        skidCtrlNext_s = inCtrl;
                        skidDataNext_s = inData;
                    end else if (deliver_s) begin
                        stateNext_s     = EMPTY;
                        mainValidNext_s = 1'b0;
                        mainCtrlNext_s  = '0;
                        mainDataNext_s  = '0;
                    end else begin
                        stateNext_s = ONE;
                    end
                end
                TWO: begin
                    if (deliver_s) begin
                        stateNext_s    = ONE;
                        mainCtrlNext_s = skidCtrl_r;
                        mainDataNext_s = skidData_r;
                        skidCtrlNext_s = '0;
                        skidDataNext_s = '0;
                    end else begin
                        stateNext_s = TWO;
                    end
                end
                default: begin
                    // An unreachable encoding recovers to an empty, zeroed stage.
                    stateNext_s     = EMPTY;
                    mainValidNext_s = 1'b0;
                    mainCtrlNext_s  = '0;
                    mainDataNext_s  = '0;
                    skidCtrlNext_s  = '0;
                    skidDataNext_s  = '0;
                end
            endcase
        end
        inReadyNext_s = (stateNext_s != TWO);
    end

    // State, entry and registered-ready flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= EMPTY;
            inReady_r   <= 1'b1;
            mainValid_r <= 1'b0;
            mainCtrl_r  <= '0;
            mainData_r  <= '0;
            skidCtrl_r  <= '0;
            skidData_r  <= '0;
        end else begin
            state_r     <= stateNext_s;
            inReady_r   <= inReadyNext_s;
            mainValid_r <= mainValidNext_s;
            mainCtrl_r  <= mainCtrlNext_s;
            mainData_r  <= mainDataNext_s;
            skidCtrl_r  <= skidCtrlNext_s;
            skidData_r  <= skidDataNext_s;
        end
    end

`else

    logic inReady_s;
    logic accept_s;
    logic deliver_s;

    assign inReady_s = !mainValid_r || outReady;
    assign inReady   = inReady_s;
    assign accept_s  = inValid && inReady_s;
    assign deliver_s = mainValid_r && outReady;

    // Single-entry next value. Flush wins. An accept also covers a same-cycle
    // deliver, because the new entry replaces the one leaving. A lone deliver
    // empties the stage and zeroes its payload.
    always_comb begin
        mainValidNext_s = mainValid_r;
        mainCtrlNext_s  = mainCtrl_r;
        mainDataNext_s  = mainData_r;
        if (flush) begin
            mainValidNext_s = 1'b0;
            mainCtrlNext_s  = '0;
            mainDataNext_s  = '0;
        end else if (accept_s) begin
            mainValidNext_s = 1'b1;
            mainCtrlNext_s  = inCtrl;
            mainDataNext_s  = inData;
        end else if (deliver_s) begin
            mainValidNext_s = 1'b0;
            mainCtrlNext_s  = '0;
            mainDataNext_s  = '0;
        end else begin
            mainValidNext_s = mainValid_r;
        end
    end

    // Entry flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            mainValid_r <= 1'b0;
            mainCtrl_r  <= '0;
            mainData_r  <= '0;
        end else begin
            mainValid_r <= mainValidNext_s;
            mainCtrl_r  <= mainCtrlNext_s;
            mainData_r  <= mainDataNext_s;
        end
    end

`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed testbench for pipe_stage_reg. It runs the default-width stage and
// a second stage with a 4-bit stall counter, which shares the same inputs, to
// check that the counter saturates.

module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        inValid;
    logic        inReady;
    logic [15:0] inCtrl;
    logic [31:0] inData;
    logic        outValid;
    logic        outReady;
    logic [15:0] outCtrl;
    logic [31:0] outData;
    logic [15:0] stallCount;

    logic        satInReady;
    logic        satOutValid;
    logic [15:0] satOutCtrl;
    logic [31:0] satOutData;
    logic [3:0]  satStall;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_stage_reg dut (
        .clk(clk), .rst(rst), .flush(flush),
        .inValid(inValid), .inReady(inReady), .inCtrl(inCtrl), .inData(inData),
        .outValid(outValid), .outReady(outReady), .outCtrl(outCtrl), .outData(outData),
        .stallCount(stallCount)
    );

    pipe_stage_reg #(.DATA_WIDTH(32), .CTRL_WIDTH(16), .STALL_CNT_WIDTH(4)) dutSat (
        .clk(clk), .rst(rst), .flush(flush),
        .inValid(inValid), .inReady(satInReady), .inCtrl(inCtrl), .inData(inData),
        .outValid(satOutValid), .outReady(outReady), .outCtrl(satOutCtrl), .outData(satOutData),
        .stallCount(satStall)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; inValid = 1'b0; outReady = 1'b0;
        inCtrl = 16'h0000; inData = 32'h0000_0000;

        // Reset state
        tick(); tick();
        chk("rst_outValid", 64'(outValid), 64'h0);
        chk("rst_outCtrl", 64'(outCtrl), 64'h0);
        chk("rst_outData", 64'(outData), 64'h0);
        chk("rst_stall", 64'(stallCount), 64'h0);
        rst = 1'b0;
        #1;
        chk("rst_inReady", 64'(inReady), 64'h1);
        chk("rst_satInReady", 64'(satInReady), 64'h1);

        // Single transfer
        outReady = 1'b1; inValid = 1'b1; inCtrl = 16'h0005; inData = 32'hDEAD_BEEF;
        tick();
        chk("single_outValid", 64'(outValid), 64'h1);
        chk("single_outCtrl", 64'(outCtrl), 64'h5);
        chk("single_outData", 64'(outData), 64'hDEAD_BEEF);
        inValid = 1'b0;
        tick();
        chk("single_outValid_after", 64'(outValid), 64'h0);
        chk("single_outData_after", 64'(outData), 64'h0);
        chk("single_outCtrl_after", 64'(outCtrl), 64'h0);

        // Streaming 1..100 with no gaps
        inValid = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            inData = 32'(i);
            inCtrl = 16'(i);
            tick();
            chk("stream_outValid", 64'(outValid), 64'h1);
            chk("stream_outData", 64'(outData), 64'(i));
        end
        inValid = 1'b0;
        tick();
        chk("stream_drained", 64'(outValid), 64'h0);
        chk("stream_stall", 64'(stallCount), 64'h0);

        // Backpressure: A accepted, B offered, 10 stalled cycles
        outReady = 1'b0; inValid = 1'b1; inCtrl = 16'h00A0; inData = 32'h0000_000A;
        tick();
        chk("bp_first_A", 64'(outData), 64'hA);
        inCtrl = 16'h00B0; inData = 32'h0000_000B;
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk("bp_hold_A", 64'(outData), 64'hA);
            chk("bp_stall", 64'(stallCount), 64'(k));
        end
        chk("bp_inReady", 64'(inReady), 64'h0);
        chk("bp_outCtrl", 64'(outCtrl), 64'hA0);
        outReady = 1'b1;
        tick();
        chk("bp_release_B", 64'(outData), 64'hB);
        chk("bp_release_Bctrl", 64'(outCtrl), 64'hB0);
        inValid = 1'b0;
        tick();
        chk("bp_drained", 64'(outValid), 64'h0);
        chk("bp_stall_kept", 64'(stallCount), 64'd10);

        // Flush while holding entries, same-cycle input 7 discarded
        outReady = 1'b0; inValid = 1'b1; inCtrl = 16'h0011; inData = 32'h0000_0011;
        tick();
        inCtrl = 16'h0022; inData = 32'h0000_0022;
        tick();
        chk("fl_pre_stall", 64'(stallCount), 64'd11);
        flush = 1'b1; inCtrl = 16'h0007; inData = 32'h0000_0007;
        tick();
        flush = 1'b0; inValid = 1'b0;
        chk("fl_outValid", 64'(outValid), 64'h0);
        chk("fl_outCtrl", 64'(outCtrl), 64'h0);
        chk("fl_outData", 64'(outData), 64'h0);
        chk("fl_stall", 64'(stallCount), 64'd11);
        outReady = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("fl_never_valid", 64'(outValid), 64'h0);
            chk("fl_never_data", 64'(outData), 64'h0);
        end

        // Flush beats a same-cycle deliver and accept
        inValid = 1'b1; inCtrl = 16'h0033; inData = 32'h0000_0033;
        tick();
        chk("fd_outData", 64'(outData), 64'h33);
        flush = 1'b1; inCtrl = 16'h0044; inData = 32'h0000_0044;
        tick();
        flush = 1'b0; inValid = 1'b0;
        chk("fd_outValid", 64'(outValid), 64'h0);
        tick();
        chk("fd_outValid2", 64'(outValid), 64'h0);
        chk("fd_outData2", 64'(outData), 64'h0);
        chk("fd_stall", 64'(stallCount), 64'd11);

        // Saturation: 20 stalled cycles on both instances
        outReady = 1'b0; inValid = 1'b1; inCtrl = 16'h0055; inData = 32'h0000_0055;
        tick();
        inValid = 1'b0;
        chk("sat_outValid", 64'(satOutValid), 64'h1);
        chk("sat_outData", 64'(satOutData), 64'h55);
        chk("sat_outCtrl", 64'(satOutCtrl), 64'h55);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("sat_main_stall", 64'(stallCount), 64'(12 + i));
            chk("sat_small_stall", 64'(satStall), ((12 + i) >= 15) ? 64'hF : 64'(12 + i));
        end
        chk("sat_final", 64'(satStall), 64'hF);

        // Clean reset, then build up stallCount=3 while full
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2_stall", 64'(stallCount), 64'h0);
        chk("rst2_satStall", 64'(satStall), 64'h0);
        chk("rst2_outValid", 64'(outValid), 64'h0);
        outReady = 1'b0; inValid = 1'b1; inCtrl = 16'h0066; inData = 32'h0000_0066;
        tick();
        inCtrl = 16'h0077; inData = 32'h0000_0077;
        tick();
        inValid = 1'b0;
        tick(); tick();
        chk("rf_pre_stall", 64'(stallCount), 64'd3);
        chk("rf_pre_inReady", 64'(inReady), 64'h0);
        chk("rf_pre_outData", 64'(outData), 64'h66);

        // rst and flush together: rst wins
        rst = 1'b1; flush = 1'b1;
        tick();
        rst = 1'b0; flush = 1'b0;
        #1;
        chk("rf_outValid", 64'(outValid), 64'h0);
        chk("rf_stall", 64'(stallCount), 64'h0);
        chk("rf_inReady", 64'(inReady), 64'h1);
        chk("rf_outData", 64'(outData), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
